// File: rtl/uart_rx.sv
// Oversampling UART receiver: synchronises RX_IN, majority-votes each bit at mid-bit,
// checks optional parity and the stop bit, and pulses exactly one result per frame.
module uart_rx #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STOP_ERR
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state;
    logic                    rx_meta;
    logic                    rx_s;
    logic [PRESCALE_W-1:0]   edge_cnt;
    logic [CNT_W-1:0]        bit_cnt;
    logic [PRESCALE_W-1:0]   p_lat;
    logic                    pen_lat;
    logic                    ptyp_lat;
    logic                    par_bad;
    logic [2:0]              smp;
    logic [DATA_WIDTH-1:0]   shreg;

    logic                    bit_end;
    logic [PRESCALE_W-1:0]   half;
    logic                    vote;
    logic                    par_exp;

    assign bit_end = (edge_cnt == p_lat - PRESCALE_W'(1));
    assign half    = p_lat >> 1;
    assign vote    = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
    assign par_exp = ptyp_lat ? ~^shreg : ^shreg;

    // Two-flop synchroniser; idle-high reset so no false start bit after reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX_IN;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            p_lat      <= '0;
            pen_lat    <= 1'b0;
            ptyp_lat   <= 1'b0;
            par_bad    <= 1'b0;
            smp        <= 3'b111;
            shreg      <= '0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STOP_ERR   <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STOP_ERR   <= 1'b0;

            if (state != IDLE) begin
                edge_cnt <= bit_end ? '0 : edge_cnt + PRESCALE_W'(1);
                if (edge_cnt == half - PRESCALE_W'(1)) smp[0] <= rx_s;
                if (edge_cnt == half)                  smp[1] <= rx_s;
                if (edge_cnt == half + PRESCALE_W'(1)) smp[2] <= rx_s;
            end

            case (state)
                IDLE: begin
                    // The detection cycle is edge 0 of the start bit
                    if (!rx_s) begin
                        state    <= START;
                        edge_cnt <= PRESCALE_W'(1);
                        bit_cnt  <= '0;
                        p_lat    <= PRESCALE;
                        pen_lat  <= PAR_EN;
                        ptyp_lat <= PAR_TYP;
                        par_bad  <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) state <= vote ? IDLE : DATA;
                end
                DATA: begin
                    if (bit_end) begin
                        shreg <= {vote, shreg[DATA_WIDTH-1:1]};
                        if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                            state <= pen_lat ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        par_bad <= (vote != par_exp);
                        state   <= STOP;
                    end
                end
                STOP: begin
                    // Stop error outranks parity error; only a clean frame updates P_DATA
                    if (bit_end) begin
                        state <= IDLE;
                        if (!vote) begin
                            STOP_ERR <= 1'b1;
                        end else if (par_bad) begin
                            PAR_ERR <= 1'b1;
                        end else begin
                            DATA_VALID <= 1'b1;
                            P_DATA     <= shreg;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx: a frame-level model predicts the
// result kind, cycle and held byte of every frame; a monitor scores each pulse.
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX_IN = 1'b1;
    logic [5:0] PRESCALE = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_ERR;
    logic       STOP_ERR;

    uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PRESCALE(PRESCALE),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(P_DATA),
        .DATA_VALID(DATA_VALID), .PAR_ERR(PAR_ERR), .STOP_ERR(STOP_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         cyc;
        logic [2:0] kind;   // {STOP_ERR, PAR_ERR, DATA_VALID}
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       got;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] last_good = 8'h00;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Score each result pulse against the oldest outstanding prediction
    always @(negedge CLK) begin
        if (!RST && (DATA_VALID || PAR_ERR || STOP_ERR)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'({STOP_ERR, PAR_ERR, DATA_VALID}), 32'd0);
            end else begin
                got = exp_q.pop_front();
                chk("pulse_cycle", 32'(cyc), 32'(got.cyc));
                chk("pulse_kind", 32'({STOP_ERR, PAR_ERR, DATA_VALID}), 32'(got.kind));
                chk("p_data", 32'(P_DATA), 32'(got.data));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Hold one bit for p cycles, optionally inverting the middle cycle
    task automatic drive_bit(input logic b, input int p, input bit spike);
        for (int i = 0; i < p; i++) begin
            RX_IN = (spike && i == p / 2) ? ~b : b;
            tick(1);
        end
    endtask

    // Entered #1 after a clock edge, so the next edge is t0
    task automatic send_frame(input logic [7:0] d, input int p, input bit pen, input bit ptyp,
                              input bit par_flip, input logic stop_b, input int spike_bit);
        int   t0;
        int   n;
        logic par_bit;
        exp_t e;
        PRESCALE = 6'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        t0       = cyc + 1;
        n        = 10 + (pen ? 1 : 0);
        par_bit  = (ptyp ? ~^d : ^d) ^ par_flip;
        if (!stop_b) begin
            e.kind = 3'b100;
        end else if (pen && par_flip) begin
            e.kind = 3'b010;
        end else begin
            e.kind    = 3'b001;
            last_good = d;
        end
        e.data = last_good;
        e.cyc  = t0 + 2 + n * p - 1;
        exp_q.push_back(e);
        drive_bit(1'b0, p, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p, spike_bit == i);
        if (pen) drive_bit(par_bit, p, 1'b0);
        drive_bit(stop_b, p, 1'b0);
        RX_IN = 1'b1;
    endtask

    task automatic drain(input string tag);
        RX_IN = 1'b1;
        tick(6);
        chk(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, 32'({P_DATA, DATA_VALID, PAR_ERR, STOP_ERR}), 32'd0);
    endtask

    initial begin
        int p;
        int pick;
        tick(3);
        chk_reset_outputs("reset_outputs");
        RST = 1'b0;
        tick(4);
        chk_reset_outputs("idle_outputs");

        // Basic 8N1 at P=8
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        drain("basic_missing");

        // Parity at P=16
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        send_frame(8'h01, 16, 1'b1, 1'b1, 1'b0, 1'b1, -1);
        drain("parity_missing");

        // Stop error then recovery
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        send_frame(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        drain("stop_missing");

        // Short glitch is rejected, then a mid-bit spike is outvoted
        PRESCALE = 6'd16;
        RX_IN = 1'b0;
        tick(4);
        RX_IN = 1'b1;
        tick(20);
        chk("glitch_p_data", 32'(P_DATA), 32'(last_good));
        send_frame(8'hC3, 16, 1'b0, 1'b0, 1'b0, 1'b1, 3);
        drain("glitch_missing");

        // Back-to-back frames with no idle gap
        send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        drain("b2b_missing");

        // Reset during data bit 3 of 0x77
        PRESCALE = 6'd8;
        PAR_EN   = 1'b0;
        drive_bit(1'b0, 8, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1, 8, 1'b0);
        RX_IN = 1'b0;
        tick(4);
        RST = 1'b1;
        #1;
        chk_reset_outputs("midframe_reset");
        tick(3);
        RX_IN = 1'b1;
        RST   = 1'b0;
        last_good = 8'h00;
        tick(2);
        chk_reset_outputs("after_reset");
        send_frame(8'h9A, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        drain("reset_missing");

        // Random frames: prescale, parity mode, errors, spikes and gaps
        for (int k = 0; k < 30; k++) begin
            pick = int'($urandom_range(0, 2));
            p    = (pick == 0) ? 8 : (pick == 1) ? 16 : 32;
            send_frame(8'($urandom), p, 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) != 0),
                       int'($urandom_range(0, 11)) - 3);
            if ($urandom_range(0, 1) == 1) tick(int'($urandom_range(1, 40)));
        end
        drain("random_missing");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver: the downstream stage that consumes the serial line produced by the transmitter (`TX_OUT` → `RX_IN`). It synchronises the line, detects the start bit, majority-samples each bit at mid-bit, optionally checks parity and the stop bit, and presents the parallel byte with a one-cycle valid pulse. `CLK` runs at PRESCALE × the bit rate.

## Interface
Parameters:
- `DATA_WIDTH`, 8, data bits per frame, sent LSB first
- `PRESCALE_W`, 6, width of the `PRESCALE` input

Ports:
- `CLK`  in  1  receiver clock, PRESCALE × bit rate
- `RST`  in  1  asynchronous, active-high reset
- `RX_IN`  in  1  serial line, idle high
- `PRESCALE`  in  PRESCALE_W  oversampling ratio; legal values 8, 16, 32; other values give undefined behaviour
- `PAR_EN`  in  1  1 = a parity bit follows the data
- `PAR_TYP`  in  1  0 = even, 1 = odd
- `P_DATA`  out  DATA_WIDTH  last good byte, held until the next good frame
- `DATA_VALID`  out  1  one-cycle pulse when `P_DATA` is updated
- `PAR_ERR`  out  1  one-cycle pulse: parity mismatch
- `STOP_ERR`  out  1  one-cycle pulse: stop bit sampled 0

## Operation
- `RX_IN` passes through a 2-flop synchroniser, reset value 1. All logic uses the synchronised `rx_s`.
- Counters:
  - `edge_cnt`, 0..PRESCALE-1: position within the current bit.
  - `bit_cnt`, 0..DATA_WIDTH-1: data bit index.
- Bit value = majority of `rx_s` sampled at edge_cnt = P/2-1, P/2 and P/2+1 (P = PRESCALE).
- `PRESCALE`, `PAR_EN` and `PAR_TYP` are latched on IDLE→START. Changes during a frame have no effect.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when `rx_s`==0, go to START. That cycle counts as edge 0, so `edge_cnt` is loaded with 1.
  - START: at edge P-1, go to DATA if the voted start bit is 0. Otherwise it was a glitch: go to IDLE with no outputs asserted.
  - DATA: each voted bit is shifted in LSB first. At edge P-1:
    - if bit_cnt < DATA_WIDTH-1, increment bit_cnt;
    - else go to PARITY if PAR_EN, otherwise STOP.
  - PARITY: at edge P-1, compare the voted bit against the expected bit. Expected = ^data for even, ~^data for odd. Record a mismatch. Go to STOP.
  - STOP: at edge P-1, go to IDLE and generate exactly one result (next cycle), with priority:
    - stop bit 0 → `STOP_ERR`;
    - else parity mismatch → `PAR_ERR`;
    - else `DATA_VALID` and load `P_DATA`.
- On any error, `P_DATA` is unchanged and `DATA_VALID` stays 0.
- `DATA_VALID`, `PAR_ERR` and `STOP_ERR` are mutually exclusive.
- Back-to-back frames: IDLE may detect a new start bit in the cycle right after STOP exits, with no idle bit required.
- Break condition (line held 0): reported as `STOP_ERR`, then the receiver re-enters START on the next cycle.

## Timing
- Reset values:
  - `P_DATA`=0, `DATA_VALID`=0, `PAR_ERR`=0, `STOP_ERR`=0
  - state IDLE, counters 0
  - synchroniser flops = 1
- Reset is asynchronous and may assert mid-frame. The frame in progress is abandoned, with no output pulse.
- Latency: let t0 be the first CLK edge at which `RX_IN` is 0, and N = DATA_WIDTH+2+PAR_EN. The result pulse is high for exactly the single cycle following edge t0+2+N·P-1.
  - Example: 8N1 at P=16 → pulse in cycle t0+162.
- Frame occupancy is N·P cycles. Throughput is therefore one frame per N·P cycles.
- Glitch rejection: a low pulse shorter than P/2-1 cycles never reaches DATA.

## Test plan
- Basic frame: P=8, PAR_EN=0, send 0xA5 (start, 1,0,1,0,0,1,0,1, stop), each bit 8 cycles → a single `DATA_VALID` pulse at t0+82, `P_DATA`=0xA5, no error pulses.
- Parity: P=16, PAR_EN=1.
  - PAR_TYP=0, 0x3C with parity bit 0 → `DATA_VALID`, `P_DATA`=0x3C.
  - Same frame with parity bit 1 → `PAR_ERR` pulse; `P_DATA` keeps 0x3C.
  - PAR_TYP=1, 0x01 with parity bit 0 → `DATA_VALID`.
- Stop error: P=8, 0x55 with stop bit 0 → `STOP_ERR` pulse, no `DATA_VALID`; the next good frame 0x12 is received correctly.
- Glitch: P=16, `RX_IN` low for 4 cycles, then high → no output pulses, FSM back in IDLE by 16 cycles later.
  - Then a single-cycle spike at mid-bit of a data bit → the majority vote keeps the correct value.
- Back-to-back and loopback: frames 0x00 then 0xFF with no idle gap → two `DATA_VALID` pulses exactly 80 cycles apart (P=8).
  - Also drive from the team's transmitter clocked at CLK/P with random bytes, both parity modes → every byte matches.
- Reset mid-frame: assert `RST` during DATA bit 3 of 0x77, release, then send 0x9A → no pulse for the aborted frame, outputs at reset values, then `P_DATA`=0x9A with `DATA_VALID`.
